ternary_stream_reducer: RTL and testbench
=========================================

# ternary_stream_reducer

Streaming reducer for packed ternary vectors: accepts a packet of TRITS-wide ternary words over a valid/ready handshake and folds it into one word using min, max or consensus (optionally sum mod 3). It reports the folded word, the beat count and an illegal-code flag.

## Interface
Parameters:
- TRITS, 4, trits per word; data width is 2*TRITS.
- LEN_W, 4, width of the beat counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op  input  2  reduction op:
  - 00 min, 01 max, 10 consensus.
  - 11 sum mod 3 when TERNARY_SUM_EN is defined, otherwise min.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  2*TRITS  trit i occupies bits [2i+1:2i].
- in_last  input  1  final beat of the packet.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  2*TRITS  reduced word.
- out_len  output  LEN_W  beats in the packet, saturating.
- out_err  output  1  at least one trit in the packet carried code 11.

## Operation
- Trit encoding: 00=0, 01=1, 10=2. Code 11 is illegal; it is treated as 2 and sets the packet error flag.
- Per-trit functions:
  - min/max: ordinary ordering.
  - consensus(a,b): a if a==b, else 1.
  - sum: (a+b) mod 3.
  - All are associative; the fold runs left to right in arrival order.
- FSM has three states: IDLE, ACCUM, DONE.
  - IDLE, on an accepted beat (in_valid & in_ready):
    - acc <= normalised in_data; op_q <= op; len <= 1; err <= (any 11 present).
    - If in_last, go to DONE; else go to ACCUM.
  - ACCUM, on an accepted beat:
    - acc <= f(op_q, acc, in); len <= len+1, saturating at 2^LEN_W-1; err |= any 11.
    - If in_last, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready = 1 in IDLE and ACCUM, 0 in DONE.
- op is sampled only on the first beat of a packet; changes to op mid-packet are ignored.
- No beat accepted in a cycle: the state holds.
- out_data, out_len and out_err are registered. They stay stable while out_valid=1 and keep their last value after the handshake.
- Single-beat packet (in_last on the first beat): out_data equals the normalised input, out_len=1.

## Timing
- Reset (async assert, outputs immediately): out_valid=0, out_data=0, out_len=0, out_err=0, in_ready=1, state IDLE. Accumulator, len, err and op_q are all cleared.
- Reset deassertion is sampled synchronously on the next clk edge.
- Reset asserted mid-packet discards the partial packet; no result is produced.
- Latency: out_valid rises on the clock edge after the in_last beat is accepted.
- Throughput:
  - One beat per cycle within a packet.
  - A packet of N beats occupies N+1 cycles minimum, because of the one-cycle DONE bubble before the next packet is accepted.
- out_valid held with out_ready=0: the block stalls indefinitely, in_ready=0, outputs stay stable.
- Beat count overflow: out_len sticks at 2^LEN_W-1. Accumulation continues correctly beyond that point.

## Configuration
- TERNARY_SUM_EN defined:
  - op=11 selects per-trit sum mod 3.
  - Logic: 0+x=x; 1+1=2; 1+2=0; 2+2=1.
- TERNARY_SUM_EN undefined:
  - No sum logic is built.
  - op=11 behaves exactly as min (00), with no error indication.

## Test plan
All vectors use TRITS=4, LEN_W=4.
- Min: op=00, beats 8'hA4 then 8'h68 (last) -> out_data=8'h64, out_len=2, out_err=0, out_valid one cycle after the last beat.
- Max and consensus: same beats with op=01 -> 8'hA8; with op=10 -> 8'h64.
- Sum, TERNARY_SUM_EN defined: op=11, same beats -> 8'h10.
- Sum, macro undefined: op=11, same beats -> 8'h64.
- Illegal code and op sampling:
  - op=00, beats 8'hFF then 8'h55 (last) -> out_data=8'h55, out_err=1.
  - op changed to 01 on the second beat -> result still 8'h55.
- Backpressure:
  - out_ready held 0 for 5 cycles: out_valid and out_data stable, in_ready=0, new in_valid ignored.
  - 17-beat packet of 8'h00 -> out_len=15.
- Reset: rst_n pulsed low after 2 of 4 beats -> out_valid=0, in_ready=1 immediately; the next 1-beat packet 8'h01 returns 8'h01, out_len=1.

Source files
------------

// File: rtl/ternary_stream_reducer_if.sv
// Stream bundle for ternary_stream_reducer: input beat channel plus result channel.
// slave is the reducer side, master is the producer/consumer side.
interface ternary_stream_reducer_if #(
    parameter int TRITS = 4,
    parameter int LEN_W = 4
);
    logic [1:0]         op;
    logic               in_valid;
    logic               in_ready;
    logic [2*TRITS-1:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [2*TRITS-1:0] out_data;
    logic [LEN_W-1:0]   out_len;
    logic               out_err;

    modport slave (
        input  op, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_len, out_err
    );

    modport master (
        output op, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_len, out_err
    );
endinterface

// File: rtl/ternary_stream_reducer.sv
// Folds a packet of packed ternary words into one word (min/max/consensus).
// Define TERNARY_SUM_EN to build the per-trit sum mod 3 on op=11; otherwise op=11 acts as min.
module ternary_stream_reducer #(
    parameter int TRITS = 4,
    parameter int LEN_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ternary_stream_reducer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state, state_next;
    logic [1:0]         op_q;
    logic [2*TRITS-1:0] acc, acc_fold, acc_next, in_norm;
    logic [LEN_W-1:0]   len, len_next;
    logic               err, err_next, in_illegal;
    logic               in_ready_int, out_valid_int, accept, first_beat;
    logic [2*TRITS-1:0] out_data_q;
    logic [LEN_W-1:0]   out_len_q;
    logic               out_err_q;

    function automatic logic [1:0] fold_trit(input logic [1:0] fop, input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        case (fop)
            2'b01:   r = (a > b) ? a : b;
            2'b10:   r = (a == b) ? a : 2'b01;
`ifdef TERNARY_SUM_EN
            2'b11: begin
                logic [2:0] s;
                s = {1'b0, a} + {1'b0, b};
                if (s >= 3'd3) s = s - 3'd3;
                r = s[1:0];
            end
`endif
            default: r = (a < b) ? a : b;
        endcase
        return r;
    endfunction

    // Illegal code 11 is folded as 2 and remembered in the error flag.
    always_comb begin
        in_norm    = '0;
        in_illegal = 1'b0;
        acc_fold   = '0;
        for (int i = 0; i < TRITS; i++) begin
            in_norm[2*i +: 2] = (bus.in_data[2*i +: 2] == 2'b11) ? 2'b10 : bus.in_data[2*i +: 2];
            in_illegal        = in_illegal | (&bus.in_data[2*i +: 2]);
        end
        for (int i = 0; i < TRITS; i++) begin
            acc_fold[2*i +: 2] = fold_trit(op_q, acc[2*i +: 2], in_norm[2*i +: 2]);
        end
    end

    always_comb begin
        first_beat = (state == IDLE);
        acc_next   = first_beat ? in_norm : acc_fold;
        len_next   = first_beat ? LEN_W'(1) : ((len == '1) ? len : len + LEN_W'(1));
        err_next   = first_beat ? in_illegal : (err | in_illegal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        in_ready_int  = 1'b0;
        out_valid_int = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready_int = 1'b1;
                accept       = bus.in_valid;
                if (bus.in_valid) begin
                    state_next = bus.in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                out_valid_int = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers are loaded only when the last beat lands, so they hold across later packets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            len        <= '0;
            err        <= 1'b0;
            op_q       <= 2'b00;
            out_data_q <= '0;
            out_len_q  <= '0;
            out_err_q  <= 1'b0;
        end else if (accept) begin
            acc <= acc_next;
            len <= len_next;
            err <= err_next;
            if (first_beat) begin
                op_q <= bus.op;
            end
            if (bus.in_last) begin
                out_data_q <= acc_next;
                out_len_q  <= len_next;
                out_err_q  <= err_next;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_data  = out_data_q;
    assign bus.out_len   = out_len_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_ternary_stream_reducer.sv
// Directed self-checking bench for ternary_stream_reducer (TRITS=4, LEN_W=4).
// The op=11 expectation follows whether TERNARY_SUM_EN is defined for the build.
module tb_ternary_stream_reducer;

    logic clk;
    logic rst_n;
    int   check_count;
    int   error_count;

    ternary_stream_reducer_if #(.TRITS(4), .LEN_W(4)) bus ();

    ternary_stream_reducer #(.TRITS(4), .LEN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Presents one beat and returns 1 time unit after the edge that accepted it.
    task automatic applyStimulus(input logic [7:0] d, input logic last, input logic [1:0] o);
        int budget;
        budget       = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.op       = o;
        while (bus.in_ready !== 1'b1 && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (bus.in_ready !== 1'b1) begin
            checkOutput("beat_accept_timeout", 32'(bus.in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expectResult(input string tag, input logic [7:0] d, input logic [3:0] len, input logic err);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_data"},  32'(bus.out_data),  32'(d));
        checkOutput({tag, "_len"},   32'(bus.out_len),   32'(len));
        checkOutput({tag, "_err"},   32'(bus.out_err),   32'(err));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_ready_back"}, 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        logic [7:0] sum_expect;
        check_count   = 0;
        error_count   = 0;
        rst_n         = 1'b0;
        bus.op        = 2'b00;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        #3;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("reset_out_data",  32'(bus.out_data),  32'd0);
        checkOutput("reset_out_len",   32'(bus.out_len),   32'd0);
        checkOutput("reset_out_err",   32'(bus.out_err),   32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(8'hA4, 1'b0, 2'b00);
        checkOutput("min_no_early_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(8'h68, 1'b1, 2'b00);
        expectResult("min", 8'h64, 4'd2, 1'b0);

        applyStimulus(8'hA4, 1'b0, 2'b01);
        applyStimulus(8'h68, 1'b1, 2'b01);
        expectResult("max", 8'hA8, 4'd2, 1'b0);

        applyStimulus(8'hA4, 1'b0, 2'b10);
        applyStimulus(8'h68, 1'b1, 2'b10);
        expectResult("consensus", 8'h64, 4'd2, 1'b0);

`ifdef TERNARY_SUM_EN
        sum_expect = 8'h10;
`else
        sum_expect = 8'h64;
`endif
        applyStimulus(8'hA4, 1'b0, 2'b11);
        applyStimulus(8'h68, 1'b1, 2'b11);
        expectResult("op11", sum_expect, 4'd2, 1'b0);

        applyStimulus(8'hFF, 1'b0, 2'b00);
        applyStimulus(8'h55, 1'b1, 2'b00);
        expectResult("illegal", 8'h55, 4'd2, 1'b1);

        applyStimulus(8'hFF, 1'b0, 2'b00);
        applyStimulus(8'h55, 1'b1, 2'b01);
        expectResult("op_sampled", 8'h55, 4'd2, 1'b1);

        applyStimulus(8'h03, 1'b1, 2'b01);
        expectResult("single_illegal", 8'h02, 4'd1, 1'b1);

        // Result held under backpressure while a competing beat is offered.
        applyStimulus(8'hA4, 1'b0, 2'b01);
        applyStimulus(8'h68, 1'b1, 2'b01);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b1;
        bus.op       = 2'b00;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid",    32'(bus.out_valid), 32'd1);
            checkOutput("stall_data",     32'(bus.out_data),  32'hA8);
            checkOutput("stall_in_ready", 32'(bus.in_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        expectResult("stall", 8'hA8, 4'd2, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("held_after_handshake", 32'(bus.out_data), 32'hA8);
        checkOutput("no_stray_result",      32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'h00, (i == 16), 2'b01);
        end
        expectResult("saturate", 8'h00, 4'd15, 1'b0);

        applyStimulus(8'h11, 1'b0, 2'b00);
        applyStimulus(8'h11, 1'b0, 2'b00);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h22;
        rst_n        = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("midreset_out_len",   32'(bus.out_len),   32'd0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postreset_no_result", 32'(bus.out_valid), 32'd0);
        applyStimulus(8'h01, 1'b1, 2'b00);
        expectResult("after_reset", 8'h01, 4'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
